rr_sel_arbiter: RTL
===================

// Module: rr_sel_arbiter
// PURPOSE
//  Two-requester round-robin arbiter that sits directly upstream of the 2:1 data mux.
//  Arbitrates two valid/ready streams A and B and drives the mux select (sel=0 -> A, sel=1 -> B).
//  Holds a grant for a whole burst, ended by `last` or by the MAX_BURST beat limit.
//  Presents one valid/ready stream downstream.
// PARAMETERS
//  DATA_W     8   width of the a/b/out data buses
//  MAX_BURST  16  max beats per grant before forced release (>=1); counter width = $clog2(MAX_BURST+1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  a_valid    in   1       requester A has a beat
//  a_last     in   1       final beat of A's burst
//  a_data     in   DATA_W  A payload
//  a_ready    out  1       A beat accepted when a_valid&a_ready
//  b_valid    in   1       requester B has a beat
//  b_last     in   1       final beat of B's burst
//  b_data     in   DATA_W  B payload
//  b_ready    out  1       B beat accepted when b_valid&b_ready
//  sel        out  1       registered mux select: 0=A, 1=B
//  out_valid  out  1       downstream beat valid
//  out_last   out  1       last flag of the selected source
//  out_data   out  DATA_W  selected payload
//  out_ready  in   1       downstream accepts the beat
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, sel=0, prio=A, beat_cnt=0.
//   Outputs while in reset: out_valid=0, a_ready=0, b_ready=0.
//  FSM states IDLE, GNT_A, GNT_B.
//   IDLE: no handshake; ready outputs=0, out_valid=0.
//    Only a_valid -> GNT_A, sel<=0.
//    Only b_valid -> GNT_B, sel<=1.
//    Both valid -> grant the side named by prio.
//    Neither -> stay in IDLE, sel unchanged.
//   GNT_x: out_valid=x_valid, out_data=x_data, out_last=x_last.
//    x_ready=out_ready; the other side's ready=0.
//    Data path is combinational through the mux, zero cycles after the grant.
//    Beat = x_valid & out_ready; each beat does beat_cnt+=1.
//    Release on a beat with x_last=1, or on the beat that makes beat_cnt==MAX_BURST.
//    On release: state->IDLE, beat_cnt<=0, prio<=other side.
//  Latency: 1 idle cycle between the request (or a release) and the first granted beat.
//   Max sustained throughput is therefore one burst per (burst_len+1) cycles.
//  sel changes only on the IDLE->GNT edge; it is never changed mid-burst.
//  Source dropping valid mid-burst: grant is held; out_valid=0 that cycle; no timeout.
//  out_ready=0: beat is stalled, beat_cnt is held, and the source must hold its data (valid/ready rule).
//  Forced release at MAX_BURST: the remaining beats of that source re-arbitrate as a new burst.
//  MAX_BURST=1: every beat is released and the grant alternates when both sources request.
//  Reset asserted mid-burst: immediate return to IDLE. The in-flight beat is not transferred.
// STRUCTURE
//  Shared package (used by the mux side and the bench):
//   state typedef {IDLE, GNT_A, GNT_B}; SEL_A=1'b0; SEL_B=1'b1.
//  One natural sub-module, burst_counter:
//   inputs clk, rst, clr, inc, with parameter MAX_BURST.
//   outputs the count and the terminal flag `at_max`.
//  The FSM, prio register and output steering live in the top module.
// TESTING
//  1 Reset: rst=1 mid-run -> same cycle out_valid=0, a_ready=b_ready=0; after release sel=0, IDLE.
//  2 A alone, 3-beat burst (last on beat 3), out_ready=1:
//    -> sel=0 one cycle after a_valid, then 3 consecutive beats, then IDLE.
//  3 A and B both valid from reset, 2-beat bursts each:
//    -> grant order A,B,A,B; sel toggles 0,1,0,1; one idle cycle between bursts.
//  4 MAX_BURST=4, B sends 6 beats with last on beat 6, A idle:
//    -> release after beat 4, re-grant to B, beats 5-6 follow.
//  5 GNT_A with out_ready low for 3 cycles:
//    -> a_ready=0, out_data stable at A's beat, beat_cnt unchanged; resumes when out_ready=1.
//  6 GNT_B while b_valid drops for 2 cycles and a_valid=1:
//    -> grant is held on B, a_ready=0, out_valid=0 for those cycles.

Source files
------------

// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter,
// used by the arbiter, the downstream mux side and the bench.
package rr_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic logic other_side(input logic side);
        return ~side;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Bundle of the two upstream valid/ready streams, the mux select and the
// merged downstream stream. slave = arbiter side, master = sources/sink side.
interface rr_sel_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              a_valid;
    logic              a_last;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic              b_last;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              sel;
    logic              out_valid;
    logic              out_last;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  a_valid, a_last, a_data,
        input  b_valid, b_last, b_data,
        input  out_ready,
        output a_ready, b_ready, sel,
        output out_valid, out_last, out_data
    );

    modport master (
        output a_valid, a_last, a_data,
        output b_valid, b_last, b_data,
        output out_ready,
        input  a_ready, b_ready, sel,
        input  out_valid, out_last, out_data
    );

endinterface

// File: rtl/rr_sel_arbiter_burst_counter.sv
// Beat counter for one grant. at_max flags that the next beat is the one
// that brings the count to MAX_BURST, so the arbiter can release on it.
module rr_sel_arbiter_burst_counter #(
    parameter  int MAX_BURST = 16,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    // clr wins over inc so the releasing beat leaves the counter at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/rr_sel_arbiter.sv
// Two-requester round-robin burst arbiter driving the 2:1 data mux select.
// A grant is held for a whole burst, ended by last or the MAX_BURST limit.
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input logic             clk,
    input logic             rst,
    rr_sel_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state;
    logic              sel_q;
    logic              prio;
    logic              gnt_a;
    logic              gnt_b;
    logic              beat;
    logic              burst_done;
    logic              at_max;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] mux_data;

    rr_sel_arbiter_burst_counter #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (burst_done),
        .inc   (beat),
        .count (beat_cnt),
        .at_max(at_max)
    );

    // sel only moves on IDLE->GNT, so the mux never switches inside a burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= SEL_A;
            prio  <= SEL_A;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.a_valid && (!bus.b_valid || prio == SEL_A)) begin
                        state <= GNT_A;
                        sel_q <= SEL_A;
                    end else if (bus.b_valid) begin
                        state <= GNT_B;
                        sel_q <= SEL_B;
                    end
                end
                GNT_A, GNT_B: begin
                    if (burst_done) begin
                        state <= IDLE;
                        prio  <= other_side(sel_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_a      = (state == GNT_A);
    assign gnt_b      = (state == GNT_B);
    assign mux_data   = (sel_q == SEL_B) ? bus.b_data : bus.a_data;
    assign beat       = bus.out_valid & bus.out_ready;
    assign burst_done = beat & (bus.out_last | at_max);

    assign bus.sel       = sel_q;
    assign bus.out_data  = mux_data;
    assign bus.out_last  = (sel_q == SEL_B) ? bus.b_last : bus.a_last;
    assign bus.out_valid = (gnt_a & bus.a_valid) | (gnt_b & bus.b_valid);
    assign bus.a_ready   = gnt_a & bus.out_ready;
    assign bus.b_ready   = gnt_b & bus.out_ready;

    beat_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        beat_cnt < CNT_W'(MAX_BURST));

endmodule
